ysyx_24110006_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the core's 16-entry integer register file. It shares the register file's single write port between the EXU result path (requester A) and the LSU load path (requester B). It registers the winning write into the register-file write signals and keeps a per-register busy vector. The IDU consults this vector to stall on RAW/WAW hazards.

---
 rtl/ysyx_24110006_wb_arbiter_pkg.sv | 27 ++
 rtl/ysyx_24110006_wb_arbiter_if.sv | 78 +++++++
 rtl/ysyx_24110006_wb_arbiter_rr_arb2.sv | 44 ++++
 rtl/ysyx_24110006_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_ysyx_24110006_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24110006_wb_arbiter_pkg.sv
// Shared types for the write-back arbiter and scoreboard.
// Round-robin arbitration is enabled by YSYX_24110006_WBARB_RR_EN.
package ysyx_24110006_wb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;
  localparam int NREG  = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] waddr;
    logic [WB_DW-1:0] wdata;
  } wb_req_t;

  function automatic req_id_e req_other(
    input req_id_e id
  );
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/ysyx_24110006_wb_arbiter_if.sv
// Issue, requester and register-file write bundle of the
// write-back arbiter; slave is the arbiter side.
interface ysyx_24110006_wb_arbiter_if
  import ysyx_24110006_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_AW,
  parameter int DATA_WIDTH = WB_DW,
  parameter int NREG       = ysyx_24110006_wb_pkg::NREG
);

  logic                  i_issue_valid;
  logic                  i_issue_wen;
  logic [ADDR_WIDTH-1:0] i_issue_rd;
  logic [ADDR_WIDTH-1:0] i_issue_rs1;
  logic [ADDR_WIDTH-1:0] i_issue_rs2;
  logic                  o_issue_ready;

  logic                  i_a_valid;
  logic [ADDR_WIDTH-1:0] i_a_waddr;
  logic [DATA_WIDTH-1:0] i_a_wdata;
  logic                  o_a_ready;

  logic                  i_b_valid;
  logic [ADDR_WIDTH-1:0] i_b_waddr;
  logic [DATA_WIDTH-1:0] i_b_wdata;
  logic                  o_b_ready;

  logic                  o_rf_valid;
  logic                  o_rf_wen;
  logic [ADDR_WIDTH-1:0] o_rf_waddr;
  logic [DATA_WIDTH-1:0] o_rf_wdata;
  logic [NREG-1:0]       o_busy;

  modport slave (
    input  i_issue_valid,
    input  i_issue_wen,
    input  i_issue_rd,
    input  i_issue_rs1,
    input  i_issue_rs2,
    output o_issue_ready,
    input  i_a_valid,
    input  i_a_waddr,
    input  i_a_wdata,
    output o_a_ready,
    input  i_b_valid,
    input  i_b_waddr,
    input  i_b_wdata,
    output o_b_ready,
    output o_rf_valid,
    output o_rf_wen,
    output o_rf_waddr,
    output o_rf_wdata,
    output o_busy
  );

  modport master (
    output i_issue_valid,
    output i_issue_wen,
    output i_issue_rd,
    output i_issue_rs1,
    output i_issue_rs2,
    input  o_issue_ready,
    output i_a_valid,
    output i_a_waddr,
    output i_a_wdata,
    input  o_a_ready,
    output i_b_valid,
    output i_b_waddr,
    output i_b_wdata,
    input  o_b_ready,
    input  o_rf_valid,
    input  o_rf_wen,
    input  o_rf_waddr,
    input  o_rf_wdata,
    input  o_busy
  );

endinterface

// File: rtl/ysyx_24110006_wb_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin with YSYX_24110006_WBARB_RR_EN,
// otherwise fixed priority with B over A and no state.
module ysyx_24110006_rr_arb2
  import ysyx_24110006_wb_pkg::*;
(
`ifdef YSYX_24110006_WBARB_RR_EN
  input  logic       i_clock,
  input  logic       i_reset_n,
`endif
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output req_id_e    o_win
);

`ifdef YSYX_24110006_WBARB_RR_EN
  // r_prio names the requester that wins a tie
  req_id_e r_prio;

  always_comb begin
    o_win = REQ_A;
    unique case (i_req)
      2'b11:   o_win = r_prio;
      2'b10:   o_win = REQ_B;
      default: o_win = REQ_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prio <= REQ_A;
    end else if (|i_req) begin
      r_prio <= req_other(o_win);
    end
  end
`else
  always_comb begin
    o_win = i_req[1] ? REQ_B : REQ_A;
  end
`endif

  assign o_gnt[0] = i_req[0] & (o_win == REQ_A);
  assign o_gnt[1] = i_req[1] & (o_win == REQ_B);

endmodule

// File: rtl/ysyx_24110006_wb_arbiter.sv
// Write-back arbiter plus busy scoreboard for the register file.
// Arbitration mode selected by YSYX_24110006_WBARB_RR_EN.
module ysyx_24110006_wb_arbiter
  import ysyx_24110006_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_AW,
  parameter int DATA_WIDTH = WB_DW,
  parameter int NREG       = ysyx_24110006_wb_pkg::NREG
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  ysyx_24110006_wb_arbiter_if.slave   bus
);

  wb_req_t          w_a;
  wb_req_t          w_b;
  wb_req_t          w_sel;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  req_id_e          w_win;
  logic             w_grant;

  logic             r_rf_valid;
  logic             r_rf_wen;
  logic [WB_AW-1:0] r_rf_waddr;
  logic [WB_DW-1:0] r_rf_wdata;

  logic [NREG-1:0]  r_busy;
  logic [NREG-1:0]  w_busy_nxt;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_rs1_idx;
  logic [IDX_W-1:0] w_rs2_idx;
  logic [IDX_W-1:0] w_clr_idx;
  logic             w_rs1_hz;
  logic             w_rs2_hz;
  logic             w_waw_hz;
  logic             w_issue_ready;
  logic             w_fire;
  logic             w_set;
  logic             w_unused_rd_msb;

  assign w_a = '{
    valid: bus.i_a_valid,
    waddr: bus.i_a_waddr,
    wdata: bus.i_a_wdata
  };
  assign w_b = '{
    valid: bus.i_b_valid,
    waddr: bus.i_b_waddr,
    wdata: bus.i_b_wdata
  };
  assign w_req = {w_b.valid, w_a.valid};

  ysyx_24110006_rr_arb2 u_arb (
`ifdef YSYX_24110006_WBARB_RR_EN
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
`endif
    .i_req     (w_req),
    .o_gnt     (w_gnt),
    .o_win     (w_win)
  );

  assign w_grant = |w_gnt;
  assign w_sel   = (w_win == REQ_B) ? w_b : w_a;

  // x0 writes are accepted but never reach the register file
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rf_valid <= 1'b0;
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_valid <= w_grant;
      r_rf_wen   <= w_grant && (w_sel.waddr != '0);
      if (w_grant) begin
        r_rf_waddr <= w_sel.waddr;
        r_rf_wdata <= w_sel.wdata;
      end
    end
  end

  assign w_rd_idx  = bus.i_issue_rd[IDX_W-1:0];
  assign w_rs1_idx = bus.i_issue_rs1[IDX_W-1:0];
  assign w_rs2_idx = bus.i_issue_rs2[IDX_W-1:0];
  assign w_clr_idx = r_rf_waddr[IDX_W-1:0];
  assign w_unused_rd_msb = bus.i_issue_rd[ADDR_WIDTH-1];

  // zero tests use the full address, lookups alias on bit 4
  assign w_rs1_hz = (bus.i_issue_rs1 != '0) && r_busy[w_rs1_idx];
  assign w_rs2_hz = (bus.i_issue_rs2 != '0) && r_busy[w_rs2_idx];
  assign w_waw_hz = bus.i_issue_wen && r_busy[w_rd_idx];

  assign w_issue_ready = !(w_rs1_hz || w_rs2_hz || w_waw_hz);
  assign w_fire = bus.i_issue_valid && w_issue_ready;
  assign w_set  = w_fire && bus.i_issue_wen
               && (w_rd_idx != '0);

  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_wen) begin
      w_busy_nxt[w_clr_idx] = 1'b0;
    end
    if (w_set) begin
      w_busy_nxt[w_rd_idx] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.o_a_ready     = w_gnt[0];
  assign bus.o_b_ready     = w_gnt[1];
  assign bus.o_issue_ready = w_issue_ready;
  assign bus.o_rf_valid    = r_rf_valid;
  assign bus.o_rf_wen      = r_rf_wen;
  assign bus.o_rf_waddr    = r_rf_waddr;
  assign bus.o_rf_wdata    = r_rf_wdata;
  assign bus.o_busy        = r_busy;

endmodule

// File: tb/tb_ysyx_24110006_wb_arbiter.sv
// Bench for the write-back arbiter: per-cycle model compare plus
// directed literal checks; honours YSYX_24110006_WBARB_RR_EN.
module tb_ysyx_24110006_wb_arbiter;

`ifdef YSYX_24110006_WBARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ysyx_24110006_wb_arbiter_if bus ();

  ysyx_24110006_wb_arbiter dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // model state: what the registered outputs must be this cycle
  bit [15:0]   m_busy;
  bit          m_pref_b;
  bit          m_valid;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit ea;
      bit eb;
      bit er;
      bit bad;
      bit [15:0] nb;
      if (!rst_n) begin
        m_busy = '0; m_pref_b = 1'b0;
        m_valid = 1'b0; m_wen = 1'b0;
        m_waddr = '0; m_wdata = '0;
      end
      ea = 1'b0;
      eb = 1'b0;
      if (bus.i_a_valid && bus.i_b_valid) begin
        if (RR) begin
          eb = m_pref_b;
          ea = !m_pref_b;
        end else begin
          eb = 1'b1;
        end
      end else begin
        ea = bus.i_a_valid;
        eb = bus.i_b_valid;
      end
      er = 1'b1;
      if (bus.i_issue_rs1 != 0 && m_busy[bus.i_issue_rs1[3:0]]) er = 1'b0;
      if (bus.i_issue_rs2 != 0 && m_busy[bus.i_issue_rs2[3:0]]) er = 1'b0;
      if (bus.i_issue_wen && m_busy[bus.i_issue_rd[3:0]]) er = 1'b0;
      bad = (bus.o_a_ready !== ea) || (bus.o_b_ready !== eb)
         || (bus.o_issue_ready !== er)
         || (bus.o_rf_valid !== m_valid) || (bus.o_rf_wen !== m_wen)
         || (bus.o_rf_waddr !== m_waddr) || (bus.o_rf_wdata !== m_wdata)
         || (bus.o_busy !== m_busy);
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t: got ar=%b br=%b ir=%b v=%b w=%b a=%h d=%h busy=%h expected ar=%b br=%b ir=%b v=%b w=%b a=%h d=%h busy=%h",
                 $time, bus.o_a_ready, bus.o_b_ready, bus.o_issue_ready,
                 bus.o_rf_valid, bus.o_rf_wen, bus.o_rf_waddr,
                 bus.o_rf_wdata, bus.o_busy, ea, eb, er, m_valid, m_wen,
                 m_waddr, m_wdata, m_busy);
      end
      if (rst_n) begin
        nb = m_busy;
        if (m_wen) nb[m_waddr[3:0]] = 1'b0;
        if (bus.i_issue_valid && er && bus.i_issue_wen
            && bus.i_issue_rd[3:0] != 0)
          nb[bus.i_issue_rd[3:0]] = 1'b1;
        nb[0] = 1'b0;
        m_busy = nb;
        if (ea || eb) begin
          m_valid  = 1'b1;
          m_waddr  = eb ? bus.i_b_waddr : bus.i_a_waddr;
          m_wdata  = eb ? bus.i_b_wdata : bus.i_a_wdata;
          m_wen    = (m_waddr != 0);
          m_pref_b = ea;
        end else begin
          m_valid = 1'b0;
          m_wen   = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         av;
    bit         bv;
    logic [4:0] aa;
    logic [4:0] ba;
  } vec_t;

  vec_t        vecs [6];
  logic [1:0]  g [4];
  logic [4:0]  w [4];
  logic [15:0] snap;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 5'd3,  5'd0};
    vecs[1] = '{1'b1, 1'b1, 5'd4,  5'd6};
    vecs[2] = '{1'b0, 1'b1, 5'd0,  5'd9};
    vecs[3] = '{1'b1, 1'b1, 5'd10, 5'd11};
    vecs[4] = '{1'b1, 1'b1, 5'd12, 5'd13};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  5'd0};

    rst_n = 1'b0;
    bus.i_issue_valid = 1'b0; bus.i_issue_wen = 1'b0;
    bus.i_issue_rd = '0; bus.i_issue_rs1 = '0; bus.i_issue_rs2 = '0;
    bus.i_a_valid = 1'b1; bus.i_a_waddr = 5'd1; bus.i_a_wdata = 32'h11;
    bus.i_b_valid = 1'b1; bus.i_b_waddr = 5'd2; bus.i_b_wdata = 32'h22;
    chk_en = 1'b1;

    tick(); tick(); #1;
    chk("rst_rf_valid", 32'(bus.o_rf_valid), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_issue_ready", 32'(bus.o_issue_ready), 32'd1);

    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      g[i] = {bus.o_b_ready, bus.o_a_ready};
      tick();
      #1;
      w[i] = bus.o_rf_waddr;
    end
    bus.i_a_valid = 1'b0;
    bus.i_b_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("grant_%0d", i), 32'(g[i]),
          (RR && i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("waddr_%0d", i), 32'(w[i]),
          (RR && i % 2 == 0) ? 32'd1 : 32'd2);
    end

    bus.i_issue_valid = 1'b1; bus.i_issue_wen = 1'b1; bus.i_issue_rd = 5'd5;
    #1 chk("issue_rd5_ready", 32'(bus.o_issue_ready), 32'd1);
    tick();
    bus.i_issue_wen = 1'b0; bus.i_issue_rd = '0; bus.i_issue_rs1 = 5'd5;
    #1 chk("raw_stall", 32'(bus.o_issue_ready), 32'd0);
    chk("busy5_set", 32'(bus.o_busy[5]), 32'd1);
    tick();
    #1 chk("raw_stall_hold", 32'(bus.o_issue_ready), 32'd0);
    bus.i_a_valid = 1'b1; bus.i_a_waddr = 5'd5; bus.i_a_wdata = 32'hDEADBEEF;
    #1 chk("a_grant_x5", 32'(bus.o_a_ready), 32'd1);
    tick();
    bus.i_a_valid = 1'b0;
    #1 chk("x5_wen", 32'(bus.o_rf_wen), 32'd1);
    chk("x5_waddr", 32'(bus.o_rf_waddr), 32'd5);
    chk("x5_wdata", bus.o_rf_wdata, 32'hDEADBEEF);
    chk("raw_stall_n1", 32'(bus.o_issue_ready), 32'd0);
    tick();
    #1 chk("raw_release", 32'(bus.o_issue_ready), 32'd1);
    chk("busy5_clr", 32'(bus.o_busy[5]), 32'd0);
    tick();
    bus.i_issue_valid = 1'b0; bus.i_issue_rs1 = '0;

    snap = bus.o_busy;
    bus.i_b_valid = 1'b1; bus.i_b_waddr = 5'd0; bus.i_b_wdata = 32'h1234;
    #1 chk("b_x0_ready", 32'(bus.o_b_ready), 32'd1);
    tick();
    bus.i_b_valid = 1'b0;
    #1 chk("x0_valid", 32'(bus.o_rf_valid), 32'd1);
    chk("x0_wen", 32'(bus.o_rf_wen), 32'd0);
    chk("x0_wdata", bus.o_rf_wdata, 32'h1234);
    tick();
    #1 chk("x0_busy", 32'(bus.o_busy), 32'(snap));

    bus.i_a_valid = 1'b1; bus.i_a_waddr = 5'd7; bus.i_a_wdata = 32'h77;
    tick();
    bus.i_a_valid = 1'b0;
    bus.i_issue_valid = 1'b1; bus.i_issue_wen = 1'b1; bus.i_issue_rd = 5'd7;
    #1 chk("x7_commit_wen", 32'(bus.o_rf_wen), 32'd1);
    chk("x7_commit_addr", 32'(bus.o_rf_waddr), 32'd7);
    chk("x7_issue_ready", 32'(bus.o_issue_ready), 32'd1);
    tick();
    bus.i_issue_valid = 1'b0; bus.i_issue_wen = 1'b0; bus.i_issue_rd = '0;
    #1 chk("x7_set_wins", 32'(bus.o_busy[7]), 32'd1);
    bus.i_issue_rs1 = 5'h17;
    #1 chk("alias_rs1_17", 32'(bus.o_issue_ready), 32'd0);
    bus.i_issue_rs1 = 5'h10;
    #1 chk("alias_rs1_10", 32'(bus.o_issue_ready), 32'd1);
    bus.i_issue_rs1 = '0;
    bus.i_a_valid = 1'b1; bus.i_a_waddr = 5'h17; bus.i_a_wdata = 32'h99;
    tick();
    bus.i_a_valid = 1'b0;
    tick();
    #1 chk("alias_clr7", 32'(bus.o_busy[7]), 32'd0);

    for (int i = 0; i < 6; i++) begin
      bus.i_a_valid = vecs[i].av; bus.i_a_waddr = vecs[i].aa;
      bus.i_a_wdata = 32'h100 + 32'(i);
      bus.i_b_valid = vecs[i].bv; bus.i_b_waddr = vecs[i].ba;
      bus.i_b_wdata = 32'h200 + 32'(i);
      tick();
    end
    bus.i_a_valid = 1'b0; bus.i_b_valid = 1'b0;
    tick();

    bus.i_issue_valid = 1'b1; bus.i_issue_wen = 1'b1; bus.i_issue_rd = 5'd3;
    tick();
    bus.i_issue_valid = 1'b0; bus.i_issue_wen = 1'b0; bus.i_issue_rd = '0;
    bus.i_a_valid = 1'b1; bus.i_a_waddr = 5'd3; bus.i_a_wdata = 32'h33;
    tick();
    bus.i_a_valid = 1'b0;
    #1 chk("pre_rst_wen", 32'(bus.o_rf_wen), 32'd1);
    chk("pre_rst_busy3", 32'(bus.o_busy[3]), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_wen", 32'(bus.o_rf_wen), 32'd0);
    chk("mid_rst_valid", 32'(bus.o_rf_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("mid_rst_waddr", 32'(bus.o_rf_waddr), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    #1 chk("post_rst_wen", 32'(bus.o_rf_wen), 32'd0);
    chk("post_rst_busy", 32'(bus.o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
